cr_fifo_rr_drain: RTL

CR_FIFO_RR_DRAIN -- requirements
Module: cr_fifo_rr_drain

---
 rtl/cr_fifo_rr_drain.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cr_fifo_rr_drain.sv
// Round-robin drain of N_SRC show-ahead FIFOs into a single registered output stream.
// Each grant pops up to BURST_MAX words back-to-back, then re-arbitrates from grant+1.
module cr_fifo_rr_drain #(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned N_DATA_BITS = 64,
  parameter int unsigned BURST_MAX   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [N_SRC-1:0]             src_empty,
  input  logic [N_SRC*N_DATA_BITS-1:0] src_rdata,
  output logic [N_SRC-1:0]             src_ren,
  output logic                         out_valid,
  output logic [N_DATA_BITS-1:0]       out_data,
  output logic [$clog2(N_SRC)-1:0]     out_src,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int unsigned SW = $clog2(N_SRC);
  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          grant_q, grant_d;
  logic [SW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]          burst_cnt_q, burst_cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [N_DATA_BITS-1:0] out_data_q, out_data_d;
  logic [SW-1:0]          out_src_q, out_src_d;

  logic [N_DATA_BITS-1:0] words [N_SRC];
  logic [SW-1:0]          pick;
  logic                   any_req;
  logic [SW-1:0]          grant_inc;
  logic [CW-1:0]          cnt_inc;
  logic                   pop;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      words[i] = src_rdata[i*N_DATA_BITS +: N_DATA_BITS];
    end
  end

  // First non-empty source at or above rr_ptr, wrapping at N_SRC.
  always_comb begin
    int unsigned   idx;
    logic [SW-1:0] idx_w;
    pick    = '0;
    any_req = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N_SRC) begin
        idx = idx - N_SRC;
      end
      idx_w = SW'(idx);
      if (!any_req && !src_empty[idx_w]) begin
        any_req = 1'b1;
        pick    = idx_w;
      end
    end
  end

  assign grant_inc = (grant_q == SW'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
  assign cnt_inc   = burst_cnt_q + 1'b1;
  assign pop       = (state_q == StBurst) && !src_empty[grant_q] && (!out_valid_q || out_ready);

  always_comb begin
    src_ren = '0;
    if (pop) begin
      src_ren[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    // Output register: load on pop, otherwise drop the word once it has been taken.
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = words[grant_q];
      out_src_d   = grant_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (en && any_req) begin
          grant_d     = pick;
          burst_cnt_d = '0;
          state_d     = StBurst;
        end
      end
      StBurst: begin
        if (src_empty[grant_q]) begin
          state_d  = StIdle;
          rr_ptr_d = grant_inc;
        end else if (pop) begin
          burst_cnt_d = cnt_inc;
          if (cnt_inc == CW'(BURST_MAX)) begin
            state_d  = StIdle;
            rr_ptr_d = grant_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q == StBurst);

endmodule
